// File: rtl/matrix_stream_out.sv
// Captures an m x n matrix on start and streams its elements row-major over valid/ready.
// Latency: element (0,0) is presented the cycle after start is sampled; done pulses one cycle after the final accept.
// Backpressure: out_ready low holds the presented element and all its tags stable until it is accepted.
module matrix_stream_out #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [2:0]                        m,
    input  logic [2:0]                        n,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix,
    output logic [DATA_W-1:0]                 out_data,
    output logic [2:0]                        out_row,
    output logic [2:0]                        out_col,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              row_end,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done,
    output logic                              dim_error
);
    localparam int NE = MAX_DIM * MAX_DIM;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;
    localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t state, state_nxt;

    logic [NE*DATA_W-1:0] cap_mat;
    logic [2:0]           cap_m, cap_n;
    logic [2:0]           row, col, row_nxt, col_nxt, m_nxt, n_nxt;
    logic                 dims_ok, load, accept, col_wrap, mat_end;
    logic [IW-1:0]        idx_nxt;
    logic [DATA_W-1:0]    elems [NE];

    // Unpack the captured matrix into an indexable element array.
    for (genvar i = 0; i < NE; i++) begin : g_elem
        assign elems[i] = cap_mat[i*DATA_W +: DATA_W];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, next row/col position and capture decision.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        load      = 1'b0;
        dims_ok   = (m != 3'd0) && (m <= DIM_MAX) && (n != 3'd0) && (n <= DIM_MAX);
        accept    = (state == SEND) && out_ready;
        col_wrap  = (col == cap_n - 3'd1);
        mat_end   = col_wrap && (row == cap_m - 3'd1);
        case (state)
            IDLE: begin
                if (start && dims_ok) begin
                    state_nxt = SEND;
                    load      = 1'b1;
                    row_nxt   = 3'd0;
                    col_nxt   = 3'd0;
                end
            end
            SEND: begin
                if (accept) begin
                    if (mat_end) begin
                        state_nxt = DONE;
                    end else if (col_wrap) begin
                        col_nxt = 3'd0;
                        row_nxt = row + 3'd1;
                    end else begin
                        col_nxt = col + 3'd1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Dimensions that will govern the next presented element.
        m_nxt   = load ? m : cap_m;
        n_nxt   = load ? n : cap_n;
        idx_nxt = IW'(row_nxt) * IW'(MAX_DIM) + IW'(col_nxt);
    end

    // Capture registers, position counters and registered outputs derived from next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_mat   <= '0;
            cap_m     <= 3'd0;
            cap_n     <= 3'd0;
            row       <= 3'd0;
            col       <= 3'd0;
            dim_error <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_row   <= 3'd0;
            out_col   <= 3'd0;
            row_end   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            row <= row_nxt;
            col <= col_nxt;
            if (load) begin
                cap_mat <= matrix;
                cap_m   <= m;
                cap_n   <= n;
            end
            // Only a start seen while idle is judged; starts during a stream are dropped.
            if (state == IDLE && start) begin
                dim_error <= !dims_ok;
            end
            out_valid <= (state_nxt == SEND);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            if (state_nxt == SEND) begin
                // On capture the register array is not yet loaded, so (0,0) comes straight from the input.
                out_data <= load ? matrix[DATA_W-1:0] : elems[idx_nxt];
                out_row  <= row_nxt;
                out_col  <= col_nxt;
                row_end  <= (col_nxt == n_nxt - 3'd1);
                out_last <= (col_nxt == n_nxt - 3'd1) && (row_nxt == m_nxt - 3'd1);
            end else begin
                out_data <= '0;
                out_row  <= 3'd0;
                out_col  <= 3'd0;
                row_end  <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end
endmodule

// File: doc/matrix_stream_out.md
MATRIX_STREAM_OUT -- requirements
Module: matrix_stream_out

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the element width in bits.
REQ-002 The block SHALL have parameter MAX_DIM, default 5, giving the maximum rows and columns.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, the synchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a request to capture and stream one matrix.
REQ-006 The block SHALL have port m, input, 3, the row count.
REQ-007 The block SHALL have port n, input, 3, the column count.
REQ-008 The block SHALL have port matrix, input, MAX_DIM*MAX_DIM*DATA_W (200), carrying the packed matrix; element (r,c) sits at bits [(r*MAX_DIM+c)*DATA_W +: DATA_W].
REQ-009 The block SHALL have port out_data, output, DATA_W, the current element.
REQ-010 The block SHALL have port out_row, output, 3, the row index of out_data.
REQ-011 The block SHALL have port out_col, output, 3, the column index of out_data.
REQ-012 The block SHALL have port out_valid, output, 1, indicating that out_data is valid.
REQ-013 The block SHALL have port out_ready, input, 1, the consumer accept signal.
REQ-014 The block SHALL have port row_end, output, 1, high while the presented element is the last in its row.
REQ-015 The block SHALL have port out_last, output, 1, high while the presented element is the last of the matrix.
REQ-016 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 The block SHALL have port done, output, 1, a one-cycle pulse after the final accept.
REQ-018 The block SHALL have port dim_error, output, 1, asserted when a start carried illegal dimensions.

Function
REQ-019 The FSM SHALL have states IDLE, SEND and DONE; all outputs SHALL be registered.
REQ-020 In IDLE, a start with 1<=m<=MAX_DIM and 1<=n<=MAX_DIM SHALL capture matrix, m and n into internal registers, clear dim_error, set row=col=0, and enter SEND.
REQ-021 In IDLE, a start with m or n equal to 0 or greater than MAX_DIM SHALL set dim_error=1, keep the FSM in IDLE, and leave out_valid low.
REQ-022 dim_error SHALL hold until the next start.
REQ-023 Latency SHALL be as follows: start sampled at edge k gives out_valid=1 with element (0,0) after edge k.
REQ-024 In SEND, out_valid SHALL be 1 and out_data SHALL equal the captured element (row,col).
REQ-025 An accept SHALL be defined as out_valid and out_ready both high at a rising edge.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_row, out_col, row_end and out_last SHALL hold stable.
REQ-027 On accept with col<n-1, the block SHALL set col=col+1.
REQ-028 On accept with col=n-1 and row<m-1, the block SHALL set col=0 and row=row+1.
REQ-029 On accept with row=m-1 and col=n-1, the block SHALL go to DONE with out_valid=0.
REQ-030 Output order SHALL be row-major; exactly m*n accepts SHALL occur per start.
REQ-031 row_end SHALL equal (col==n-1) and out_last SHALL equal (row==m-1 && col==n-1) while out_valid=1; both SHALL be 0 otherwise.
REQ-032 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-033 Elements outside m x n SHALL never be presented.
REQ-034 start while busy=1 SHALL be ignored, including its dimension check.
REQ-035 Changes on matrix, m or n after capture SHALL NOT affect the stream in progress.
REQ-036 A 1x1 matrix SHALL present one element with row_end=1 and out_last=1.

Reset
REQ-037 With reset=0 at a rising edge, the block SHALL enter IDLE and drive out_data, out_row, out_col, out_valid, row_end, out_last, busy, done and dim_error to 0.
REQ-038 Reset SHALL have priority over start and accept, including mid-stream; the aborted stream SHALL NOT produce done.

Verification
REQ-039 m=2, n=3, matrix {4,5,6;5,6,7}, out_ready=1, start at edge k SHALL give out_data 4,5,6,5,6,7 after edges k..k+5, row_end on the 3rd and 6th elements, out_last on the 6th, and done=1 after edge k+6.
REQ-040 The same matrix with out_ready toggling 1,0,0,1,... SHALL give the identical sequence, with outputs stable during every stall cycle.
REQ-041 start with m=0, n=3, then with m=2, n=6, SHALL each give dim_error=1, out_valid=0, busy=0; a following legal start SHALL clear dim_error.
REQ-042 m=n=5 with element (r,c)=r*5+c SHALL give 25 elements 0..24, with the last element (4,4)=24 taken from bits 199:192.
REQ-043 reset=0 after 3 accepts on a 2x3 matrix SHALL give out_valid=0, busy=0 and no done on the next cycle; a new start SHALL restart at element (0,0).
REQ-044 start pulsed mid-stream with a different matrix and m=1 SHALL leave the original 2x3 stream unchanged, with no dim_error.
